detect_scheduler: RTL and testbench

DETECT_SCHEDULER -- requirements
Module: detect_scheduler

---
 rtl/detect_scheduler.sv | 109 ++++++++++
 tb/tb_detect_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_scheduler.sv
// Round-robin scheduler for four serial channels sharing one Mealy "11" detector.
// Ports: clk, reset (async, active-low), req[3:0], in[3:0] -> gnt[3:0], busy, out, done, done_id[1:0], done_hits[7:0].
module detect_scheduler #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       out,
  output logic       done,
  output logic [1:0] done_id,
  output logic [7:0] done_hits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BIT = 8'(BURST_LEN - 1);

  state_t     state;
  logic [1:0] ch;
  logic [1:0] last;
  logic [7:0] bit_cnt;
  logic [7:0] hit_cnt;
  logic       prev;
  logic       sel;
  logic [1:0] pick;
  logic [1:0] idx;

  // Scan from last+4 down to last+1 so the closest requester wins.
  always_comb begin
    pick = last + 2'd1;
    idx  = last + 2'd1;
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (req[idx]) pick = idx;
    end
  end

  assign sel = in[ch];
  assign out = busy & sel & prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ch        <= 2'd0;
      // last=3 makes channel 0 the first in line
      last      <= 2'd3;
      bit_cnt   <= 8'd0;
      hit_cnt   <= 8'd0;
      prev      <= 1'b0;
      gnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 2'd0;
      done_hits <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          done      <= 1'b0;
          done_id   <= 2'd0;
          done_hits <= 8'd0;
          if (req != 4'd0) begin
            state   <= BURST;
            ch      <= pick;
            last    <= pick;
            gnt     <= 4'(1) << pick;
            busy    <= 1'b1;
            bit_cnt <= 8'd0;
            hit_cnt <= 8'd0;
            prev    <= 1'b0;
          end
        end
        BURST: begin
          prev    <= sel;
          bit_cnt <= bit_cnt + 8'd1;
          if (out) hit_cnt <= hit_cnt + 8'd1;
          if (bit_cnt == LAST_BIT) begin
            state     <= DONE;
            gnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b1;
            done_id   <= ch;
            done_hits <= hit_cnt + {7'd0, out};
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          done_id   <= 2'd0;
          done_hits <= 8'd0;
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detect_scheduler.sv
// Scoreboard bench for detect_scheduler (BURST_LEN=8).
// Expected (channel, hits) pushed per burst, popped on done.
module tb_detect_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       busy;
  logic       dout;
  logic       done;
  logic [1:0] done_id;
  logic [7:0] done_hits;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] hits;
  } exp_t;

  exp_t sb[$];

  detect_scheduler #(.BURST_LEN(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .req       (req),
    .in        (din),
    .gnt       (gnt),
    .busy      (busy),
    .out       (dout),
    .done      (done),
    .done_id   (done_id),
    .done_hits (done_hits)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] count_hits(input logic [7:0] bits);
    logic       p;
    logic [7:0] n;
    p = 1'b0;
    n = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (p && bits[i]) n = n + 8'd1;
      p = bits[i];
    end
    return n;
  endfunction

  task automatic wait_grant(input logic [3:0] exp, output int waits);
    waits = 0;
    while (gnt === 4'd0 && waits < 30) begin
      @(negedge clk);
      waits++;
    end
    total++;
    if (gnt !== exp) begin
      bad++;
      $display("FAIL grant: got=%b want=%b after %0d cycles", gnt, exp, waits);
    end
  endtask

  // Called at the first BURST negedge; returns at the following IDLE negedge.
  task automatic feed(input logic [1:0] ch, input logic [7:0] bits);
    exp_t       e;
    logic       p;
    logic       eo;
    logic [3:0] v;
    e.id   = ch;
    e.hits = count_hits(bits);
    sb.push_back(e);
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v      = 4'($urandom);
      v[ch]  = bits[i];
      din    = v;
      #1;
      eo = p & bits[i];
      total++;
      if (dout !== eo) begin
        bad++;
        $display("FAIL out ch%0d bit%0d: got=%b want=%b", ch, i, dout, eo);
      end
      total++;
      if (gnt !== (4'(1) << ch) || busy !== 1'b1) begin
        bad++;
        $display("FAIL burst_gnt ch%0d bit%0d: gnt=%b busy=%b", ch, i, gnt, busy);
      end
      p = bits[i];
      @(negedge clk);
    end
    din = 4'($urandom);
    #1;
    total++;
    if (done !== 1'b1 || dout !== 1'b0 || gnt !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_state: done=%b out=%b gnt=%b busy=%b want 1 0 0000 0",
               done, dout, gnt, busy);
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: empty at done");
    end else begin
      e = sb.pop_front();
      total++;
      if (done_id !== e.id || done_hits !== e.hits) begin
        bad++;
        $display("FAIL done_data: id=%0d hits=%0d want id=%0d hits=%0d",
                 done_id, done_hits, e.id, e.hits);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (done !== 1'b0 || done_id !== 2'd0 || done_hits !== 8'd0 || gnt !== 4'd0) begin
      bad++;
      $display("FAIL idle_after_done: done=%b id=%0d hits=%0d gnt=%b",
               done, done_id, done_hits, gnt);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'd0;
    din   = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'd0;
    din   = 4'hF;
    #1;
    total++;
    if (gnt !== 4'd0 || busy !== 1'b0 || dout !== 1'b0 || done !== 1'b0 ||
        done_id !== 2'd0 || done_hits !== 8'd0) begin
      bad++;
      $display("FAIL reset: gnt=%b busy=%b out=%b done=%b id=%0d hits=%0d",
               gnt, busy, dout, done, done_id, done_hits);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    din   = 4'd0;
    @(negedge clk);
    #1;
    total++;
    if (gnt !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req: gnt=%b busy=%b", gnt, busy);
    end
  endtask

  task automatic test_basic();
    int w;
    req = 4'b0001;
    wait_grant(4'b0001, w);
    req = 4'd0;
    feed(2'd0, 8'hCE);
  endtask

  task automatic test_round_robin();
    int w;
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(seq[k], w);
      if (k > 0) begin
        total++;
        if (w !== 1) begin
          bad++;
          $display("FAIL rr_gap: grant %0d after %0d cycles want 1", k, w);
        end
      end
      if (k == 4) req = 4'd0;
      feed(2'(k % 4), 8'($urandom));
    end
  endtask

  task automatic test_prev_clear();
    int w;
    do_reset();
    req = 4'b0011;
    wait_grant(4'b0001, w);
    feed(2'd0, 8'hFF);
    wait_grant(4'b0010, w);
    req = 4'd0;
    feed(2'd1, 8'b0000_0101);
  endtask

  task automatic test_short_req();
    int w;
    req = 4'b0100;
    wait_grant(4'b0100, w);
    req = 4'd0;
    feed(2'd2, 8'hFF);
  endtask

  task automatic test_noise();
    int w;
    req = 4'b1000;
    wait_grant(4'b1000, w);
    req = 4'd0;
    feed(2'd3, 8'h00);
  endtask

  task automatic test_reset_mid();
    int w;
    req = 4'b0010;
    wait_grant(4'b0010, w);
    req = 4'd0;
    for (int i = 0; i < 3; i++) begin
      din = 4'b0010;
      @(negedge clk);
    end
    din = 4'b0010;
    #1;
    total++;
    if (dout !== 1'b1) begin
      bad++;
      $display("FAIL mid_out_before_reset: got=%b want=1", dout);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 4'd0 || busy !== 1'b0 || dout !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: gnt=%b busy=%b out=%b done=%b", gnt, busy, dout, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL abort_done: done=%b want 0", done);
      end
    end
    req   = 4'b0011;
    rst_n = 1'b1;
    wait_grant(4'b0001, w);
    total++;
    if (w !== 1) begin
      bad++;
      $display("FAIL first_grant_latency: %0d cycles want 1", w);
    end
    req = 4'd0;
    feed(2'd0, 8'($urandom));
  endtask

  initial begin
    req   = 4'd0;
    din   = 4'd0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_prev_clear();
    test_short_req();
    test_noise();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
